template_db_loader: RTL and testbench

- Upstream feeder for the per-pin double-buffered template registers.
- Accepts a tester template from the host as a stream of WORD_W-bit words. Drives each pin register's D/LOAD from those words.
- Once a complete template is buffered, issues one TRANSFER pulse aligned to the next vector boundary, so all pins switch template together.

---
 rtl/template_db_loader.sv | 120 ++++++++++++
 tb/tb_template_db_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/template_db_loader.sv
// Streams host template words into the per-pin D/LOAD strobes and commits a full template with one TRANSFER.
// Optional FORCE_XFER commit input is enabled by defining TEMPLATE_DB_LOADER_FORCE_XFER_EN.
module template_db_loader #(
    parameter int NUM_PINS = 32,
    parameter int WORD_W   = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                WR_VALID,
    output logic                WR_READY,
    input  logic [WORD_W-1:0]   WR_DATA,
    input  logic                WR_LAST,
    input  logic                VEC_STROBE,
    input  logic                ERR_CLR,
`ifdef TEMPLATE_DB_LOADER_FORCE_XFER_EN
    input  logic                FORCE_XFER,
`endif
    output logic [NUM_PINS-1:0] PIN_D,
    output logic [NUM_PINS-1:0] PIN_LOAD,
    output logic                TRANSFER,
    output logic                BUSY,
    output logic                ERR
);

    localparam int NUM_WORDS = (NUM_PINS + WORD_W - 1) / WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        PENDING = 2'd2,
        XFER    = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [NUM_PINS-1:0] pin_d;
    logic [NUM_PINS-1:0] pin_load;
    logic                transfer;
    logic                err;

    logic commit;
    logic accept;
    logic at_end;
    logic err_set;

`ifdef TEMPLATE_DB_LOADER_FORCE_XFER_EN
    assign commit = VEC_STROBE | FORCE_XFER;
`else
    assign commit = VEC_STROBE;
`endif

    assign WR_READY = (state == IDLE) || (state == LOADING);
    assign accept   = WR_VALID && WR_READY;
    assign at_end   = (idx == LAST_IDX);
    // Framing error: final word without LAST, or LAST arriving before the final word.
    assign err_set  = accept && (at_end ? !WR_LAST : WR_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            idx      <= '0;
            pin_d    <= '0;
            pin_load <= '0;
            transfer <= 1'b0;
            err      <= 1'b0;
        end else begin
            pin_load <= '0;
            transfer <= 1'b0;
            err      <= err_set | (err & ~ERR_CLR);

            for (int p = 0; p < NUM_PINS; p++) begin
                if (accept && (idx == IDX_W'(p / WORD_W))) begin
                    pin_d[p]    <= WR_DATA[p % WORD_W];
                    pin_load[p] <= 1'b1;
                end
            end

            case (state)
                IDLE, LOADING: begin
                    if (accept) begin
                        if (at_end) begin
                            state <= PENDING;
                            idx   <= '0;
                        end else if (WR_LAST) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            state <= LOADING;
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                PENDING: begin
                    // The last LOAD pulse has already been consumed by the time the strobe is sampled here.
                    if (commit) begin
                        state    <= XFER;
                        transfer <= 1'b1;
                    end
                end
                XFER: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign PIN_D    = pin_d;
    assign PIN_LOAD = pin_load;
    assign TRANSFER = transfer;
    assign BUSY     = (state != IDLE);
    assign ERR      = err;

endmodule

// File: tb/tb_template_db_loader.sv
// Bench for template_db_loader at NUM_PINS=20, WORD_W=8: directed vector table, corner sequences, random vs model.
module tb_template_db_loader;

    localparam int NP = 20;
    localparam int W  = 8;
    localparam int NW = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          WR_VALID = 1'b0;
    logic          WR_READY;
    logic [W-1:0]  WR_DATA = '0;
    logic          WR_LAST = 1'b0;
    logic          VEC_STROBE = 1'b0;
    logic          ERR_CLR = 1'b0;
`ifdef TEMPLATE_DB_LOADER_FORCE_XFER_EN
    logic          FORCE_XFER = 1'b0;
`endif
    logic [NP-1:0] PIN_D;
    logic [NP-1:0] PIN_LOAD;
    logic          TRANSFER;
    logic          BUSY;
    logic          ERR;

    template_db_loader #(.NUM_PINS(NP), .WORD_W(W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .WR_VALID   (WR_VALID),
        .WR_READY   (WR_READY),
        .WR_DATA    (WR_DATA),
        .WR_LAST    (WR_LAST),
        .VEC_STROBE (VEC_STROBE),
        .ERR_CLR    (ERR_CLR),
`ifdef TEMPLATE_DB_LOADER_FORCE_XFER_EN
        .FORCE_XFER (FORCE_XFER),
`endif
        .PIN_D      (PIN_D),
        .PIN_LOAD   (PIN_LOAD),
        .TRANSFER   (TRANSFER),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          vld;
        logic [W-1:0]  dat;
        logic          last;
        logic          strb;
        logic          clr;
        logic [NP-1:0] load;
        logic [NP-1:0] d;
        logic          xfer;
        logic          busy;
        logic          rdy;
        logic          err;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic vec_t mk(logic vld, logic [W-1:0] dat, logic last, logic strb, logic clr,
                                logic [NP-1:0] load, logic [NP-1:0] d,
                                logic xfer, logic busy, logic rdy, logic err);
        vec_t v;
        v.vld = vld; v.dat = dat; v.last = last; v.strb = strb; v.clr = clr;
        v.load = load; v.d = d; v.xfer = xfer; v.busy = busy; v.rdy = rdy; v.err = err;
        return v;
    endfunction

    task automatic drive(logic vld, logic [W-1:0] dat, logic last, logic strb, logic clr);
        WR_VALID = vld; WR_DATA = dat; WR_LAST = last; VEC_STROBE = strb; ERR_CLR = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Observed vector: {load, d, transfer, busy, ready, err}
    task automatic check(string name, logic [NP-1:0] load, logic [NP-1:0] d,
                         logic xfer, logic busy, logic rdy, logic err);
        logic [2*NP+3:0] act;
        logic [2*NP+3:0] exp;
        act = {PIN_LOAD, PIN_D, TRANSFER, BUSY, WR_READY, ERR};
        exp = {load, d, xfer, busy, rdy, err};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got load=%h d=%h xfer=%b busy=%b rdy=%b err=%b, expected load=%h d=%h xfer=%b busy=%b rdy=%b err=%b",
                     name, PIN_LOAD, PIN_D, TRANSFER, BUSY, WR_READY, ERR, load, d, xfer, busy, rdy, err);
        end
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference model state
    int            m_cnt;
    bit            m_pend;
    bit            m_xfer;
    bit            m_err;
    logic [NP-1:0] m_d;
    logic [NP-1:0] m_load;
    bit            m_tr;

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_xfer = 0; m_err = 0; m_d = '0; m_load = '0; m_tr = 0;
    endtask

    task automatic model_edge(logic vld, logic [W-1:0] dat, logic last, logic strb, logic clr);
        bit new_err;
        new_err = 0;
        m_load  = '0;
        m_tr    = 0;
        if (m_xfer) begin
            m_xfer = 0;
        end else if (m_pend) begin
            if (strb) begin
                m_pend = 0;
                m_xfer = 1;
                m_tr   = 1;
            end
        end else if (vld) begin
            for (int i = 0; i < W; i++) begin
                int p;
                p = m_cnt * W + i;
                if (p < NP) begin
                    m_d[p]    = dat[i];
                    m_load[p] = 1'b1;
                end
            end
            if (m_cnt == NW - 1) begin
                m_pend  = 1;
                m_cnt   = 0;
                new_err = !last;
            end else if (last) begin
                m_cnt   = 0;
                new_err = 1;
            end else begin
                m_cnt++;
            end
        end
        m_err = new_err | (m_err & !clr);
    endtask

    vec_t vecs[38];

    initial begin
        // Main template, strobe 5 cycles after the last word
        vecs[0]  = mk(1, 8'hA5, 0, 0, 0, 20'h000FF, 20'h000A5, 0, 1, 1, 0);
        vecs[1]  = mk(1, 8'h3C, 0, 0, 0, 20'h0FF00, 20'h03CA5, 0, 1, 1, 0);
        vecs[2]  = mk(1, 8'hF9, 1, 0, 0, 20'hF0000, 20'h93CA5, 0, 1, 0, 0);
        vecs[3]  = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h93CA5, 0, 1, 0, 0);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h93CA5, 0, 1, 0, 0);
        vecs[5]  = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h93CA5, 0, 1, 0, 0);
        vecs[6]  = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h93CA5, 0, 1, 0, 0);
        vecs[7]  = mk(0, 8'h00, 0, 1, 0, 20'h00000, 20'h93CA5, 1, 1, 0, 0);
        vecs[8]  = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h93CA5, 0, 0, 1, 0);
        // Strobe while loading is ignored
        vecs[9]  = mk(1, 8'h11, 0, 0, 0, 20'h000FF, 20'h93C11, 0, 1, 1, 0);
        vecs[10] = mk(0, 8'h00, 0, 1, 0, 20'h00000, 20'h93C11, 0, 1, 1, 0);
        vecs[11] = mk(1, 8'h22, 0, 0, 0, 20'h0FF00, 20'h92211, 0, 1, 1, 0);
        vecs[12] = mk(1, 8'h03, 1, 0, 0, 20'hF0000, 20'h32211, 0, 1, 0, 0);
        vecs[13] = mk(0, 8'h00, 0, 1, 0, 20'h00000, 20'h32211, 1, 1, 0, 0);
        vecs[14] = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h32211, 0, 0, 1, 0);
        // Early LAST on word 1, then clear and a full template
        vecs[15] = mk(1, 8'h44, 0, 0, 0, 20'h000FF, 20'h32244, 0, 1, 1, 0);
        vecs[16] = mk(1, 8'h55, 1, 0, 0, 20'h0FF00, 20'h35544, 0, 0, 1, 1);
        vecs[17] = mk(0, 8'h00, 0, 1, 0, 20'h00000, 20'h35544, 0, 0, 1, 1);
        vecs[18] = mk(0, 8'h00, 0, 0, 1, 20'h00000, 20'h35544, 0, 0, 1, 0);
        vecs[19] = mk(1, 8'h01, 0, 0, 0, 20'h000FF, 20'h35501, 0, 1, 1, 0);
        vecs[20] = mk(1, 8'h02, 0, 0, 0, 20'h0FF00, 20'h30201, 0, 1, 1, 0);
        vecs[21] = mk(1, 8'h0F, 1, 0, 0, 20'hF0000, 20'hF0201, 0, 1, 0, 0);
        vecs[22] = mk(0, 8'h00, 0, 1, 0, 20'h00000, 20'hF0201, 1, 1, 0, 0);
        vecs[23] = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'hF0201, 0, 0, 1, 0);
        // New error and ERR_CLR on the same edge: set wins
        vecs[24] = mk(1, 8'hAA, 1, 0, 1, 20'h000FF, 20'hF02AA, 0, 0, 1, 1);
        vecs[25] = mk(0, 8'h00, 0, 0, 1, 20'h00000, 20'hF02AA, 0, 0, 1, 0);
        // Missing LAST on final word still commits, with ERR
        vecs[26] = mk(1, 8'h00, 0, 0, 0, 20'h000FF, 20'hF0200, 0, 1, 1, 0);
        vecs[27] = mk(1, 8'h00, 0, 0, 0, 20'h0FF00, 20'hF0000, 0, 1, 1, 0);
        vecs[28] = mk(1, 8'h00, 0, 0, 0, 20'hF0000, 20'h00000, 0, 1, 0, 1);
        vecs[29] = mk(0, 8'h00, 0, 1, 1, 20'h00000, 20'h00000, 1, 1, 0, 0);
        vecs[30] = mk(0, 8'h00, 0, 0, 0, 20'h00000, 20'h00000, 0, 0, 1, 0);
        // WR_VALID held through PENDING/XFER: next word accepted only back in IDLE
        vecs[31] = mk(1, 8'h01, 0, 0, 0, 20'h000FF, 20'h00001, 0, 1, 1, 0);
        vecs[32] = mk(1, 8'h02, 0, 0, 0, 20'h0FF00, 20'h00201, 0, 1, 1, 0);
        vecs[33] = mk(1, 8'h03, 1, 0, 0, 20'hF0000, 20'h30201, 0, 1, 0, 0);
        vecs[34] = mk(1, 8'h77, 0, 0, 0, 20'h00000, 20'h30201, 0, 1, 0, 0);
        vecs[35] = mk(1, 8'h77, 0, 1, 0, 20'h00000, 20'h30201, 1, 1, 0, 0);
        vecs[36] = mk(1, 8'h77, 0, 0, 0, 20'h00000, 20'h30201, 0, 0, 1, 0);
        vecs[37] = mk(1, 8'h77, 0, 0, 0, 20'h000FF, 20'h30277, 0, 1, 1, 0);

        #1 RST_N = 1'b0;
        #2;
        check("reset_state", '0, '0, 0, 0, 1, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("idle_after_reset", '0, '0, 0, 0, 1, 0);

        for (int i = 0; i < 38; i++) begin
            drive(vecs[i].vld, vecs[i].dat, vecs[i].last, vecs[i].strb, vecs[i].clr);
            tick();
            check($sformatf("vec%0d", i), vecs[i].load, vecs[i].d, vecs[i].xfer,
                  vecs[i].busy, vecs[i].rdy, vecs[i].err);
        end

        // Reset mid-load: word 1 of the pending template, then async reset between edges
        drive(1, 8'h88, 0, 0, 0);
        tick();
        check("midload_word1", 20'h0FF00, 20'h38877, 0, 1, 1, 0);
        drive(0, 8'h00, 0, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        check("async_reset_clears", '0, '0, 0, 0, 1, 0);
        tick();
        #3 RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 0, 1, 0);
            tick();
            check_bit($sformatf("no_xfer_after_reset%0d", i), TRANSFER, 1'b0);
        end
        drive(0, 8'h00, 0, 0, 0);

`ifdef TEMPLATE_DB_LOADER_FORCE_XFER_EN
        drive(1, 8'h11, 0, 0, 0); tick();
        drive(1, 8'h22, 0, 0, 0); tick();
        drive(1, 8'h33, 1, 0, 0); tick();
        check("force_pending", 20'hF0000, 20'h32211, 0, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        FORCE_XFER = 1'b1;
        tick();
        FORCE_XFER = 1'b0;
        check("force_xfer", '0, 20'h32211, 1, 1, 0, 0);
        tick();
        check("force_back_idle", '0, 20'h32211, 0, 0, 1, 0);
        FORCE_XFER = 1'b1;
        tick();
        FORCE_XFER = 1'b0;
        check("force_idle_ignored", '0, 20'h32211, 0, 0, 1, 0);
`endif

        // Randomised run against the reference model
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        model_reset();
        check("random_reset", m_load, m_d, m_tr, 0, 1, m_err);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic          vld;
            logic [W-1:0]  dat;
            logic          last;
            logic          strb;
            logic          clr;
            vld  = ($urandom_range(0, 3) != 0);
            dat  = W'($urandom);
            last = ($urandom_range(0, 3) == 0);
            strb = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            @(posedge CLK);
            #1;
            drive(vld, dat, last, strb, clr);
            model_edge(vld, dat, last, strb, clr);
            @(posedge CLK);
            #1;
            check($sformatf("rand%0d", c), m_load, m_d, m_tr,
                  (m_cnt != 0) || m_pend || m_xfer, !m_pend && !m_xfer, m_err);
            drive(0, 8'h00, 0, 0, 0);
            model_edge(0, 8'h00, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
